// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone slave driving an asynchronous 32-bit SRAM
module wb_sram_slave #(
  parameter int ADDR_WIDTH  = 20,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_PULSE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [31:0]           sram_data_i,
  output logic [31:0]           sram_data_o,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
  localparam int CW       = $clog2(MAX_WAIT) + 1;

  typedef enum logic [2:0] {IDLE, READ, W_SETUP, W_PULSE, W_HOLD, DONE} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic                  abort_q, abort_d;
  logic [31:0]           wb_dat_d, sram_data_d;
  logic [ADDR_WIDTH-1:0] sram_addr_d;
  logic                  ack_d, data_oe_d, ce_n_d, oe_n_d, we_n_d;
  logic [3:0]            be_n_d;

  // Byte-offset bits and address bits beyond the SRAM are deliberately dropped.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

  // State, wait counter and every output are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      abort_q      <= 1'b0;
      wb_dat_o     <= '0;
      wb_ack_o     <= 1'b0;
      sram_addr    <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'hf;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      abort_q      <= abort_d;
      wb_dat_o     <= wb_dat_d;
      wb_ack_o     <= ack_d;
      sram_addr    <= sram_addr_d;
      sram_data_o  <= sram_data_d;
      sram_data_oe <= data_oe_d;
      sram_ce_n    <= ce_n_d;
      sram_oe_n    <= oe_n_d;
      sram_we_n    <= we_n_d;
      sram_be_n    <= be_n_d;
    end
  end

  // Next state plus the SRAM control levels for the cycle being entered.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    abort_d     = abort_q;
    wb_dat_d    = wb_dat_o;
    sram_addr_d = sram_addr;
    sram_data_d = sram_data_o;
    ack_d       = 1'b0;
    data_oe_d   = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = 4'hf;
    case (state)
      IDLE: begin
        abort_d = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          sram_addr_d = wb_adr_i[ADDR_WIDTH+1:2];
          ce_n_d      = 1'b0;
          if (wb_we_i) begin
            sram_data_d = wb_dat_i;
            data_oe_d   = 1'b1;
            be_n_d      = ~wb_sel_i;
            state_d     = W_SETUP;
          end else begin
            oe_n_d  = 1'b0;
            be_n_d  = 4'h0;
            cnt_d   = CW'(READ_WAIT - 1);
            state_d = READ;
          end
        end
      end
      READ: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt == '0) begin
          wb_dat_d = sram_data_i;
          ack_d    = wb_stb_i;
          state_d  = DONE;
        end else begin
          cnt_d  = cnt - CW'(1);
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
          be_n_d = 4'h0;
        end
      end
      W_SETUP: begin
        abort_d   = abort_q | ~wb_cyc_i;
        ce_n_d    = 1'b0;
        data_oe_d = 1'b1;
        be_n_d    = sram_be_n;
        we_n_d    = 1'b0;
        cnt_d     = CW'(WRITE_PULSE - 1);
        state_d   = W_PULSE;
      end
      W_PULSE: begin
        abort_d   = abort_q | ~wb_cyc_i;
        ce_n_d    = 1'b0;
        data_oe_d = 1'b1;
        be_n_d    = sram_be_n;
        if (cnt == '0) begin
          state_d = W_HOLD;
        end else begin
          cnt_d  = cnt - CW'(1);
          we_n_d = 1'b0;
        end
      end
      W_HOLD: begin
        abort_d = abort_q | ~wb_cyc_i;
        ack_d   = wb_cyc_i & wb_stb_i & ~abort_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - self-checking bench for wb_sram_slave
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_o, sram_data_i, sram_data_o;
  logic        wb_ack_o, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;

  wb_sram_slave #(.ADDR_WIDTH(20), .READ_WAIT(2), .WRITE_PULSE(2)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sram_addr(sram_addr), .sram_data_i(sram_data_i), .sram_data_o(sram_data_o),
    .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // Asynchronous SRAM model: 256 words, aliased on the low address bits.
  logic [31:0] mem [0:255];
  int          oe_low_total = 0;
  int          we_low_total = 0;
  logic [19:0] last_addr = '0;
  logic [3:0]  last_be = 4'hf;
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (!rst && !sram_ce_n) begin
      last_addr = sram_addr;
      if (!sram_oe_n) begin
        oe_low_total++;
        last_be = sram_be_n;
      end
      if (!sram_we_n) begin
        we_low_total++;
        last_be = sram_be_n;
        if (sram_data_oe)
          for (int b = 0; b < 4; b++)
            if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] = sram_data_o[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [19:0] addr;
    int          lat;
    int          low;
    logic [3:0]  be;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;
  logic safety_en = 1'b0;
  logic prev_we_n = 1'b1;
  logic prev_oe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check the data-bus handover rules.
  task automatic step();
    @(negedge clk);
    if (safety_en && (sram_we_n != prev_we_n || sram_data_oe != prev_oe)) begin
      nvec++;
      if ((prev_we_n && !sram_we_n && !prev_oe && sram_data_oe) ||
          (!prev_we_n && sram_we_n && prev_oe && !sram_data_oe)) begin
        nmis++;
        $display("FAIL bus_safety: we_n %b->%b data_oe %b->%b", prev_we_n, sram_we_n, prev_oe, sram_data_oe);
      end
    end
    prev_we_n = sram_we_n;
    prev_oe   = sram_data_oe;
  endtask

  task automatic wait_ack(output logic got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wb_ack_o) begin
        got = 1'b1;
        return;
      end
    end
    nvec++;
    nmis++;
    $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
    sb.delete();
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      nvec++;
      nmis++;
      $display("FAIL unexpected_ack: got ack expected none at cycle %0d", cyc_cnt);
    end else begin
      e = sb.pop_front();
      check("ack_cycle", 32'(cyc_cnt), 32'(e.due));
      if (e.is_rd) check("rdata", wb_dat_o, e.dat);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_sel_i = sel;
    wb_dat_i = dat;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic xfer(input vec_t v);
    exp_t e;
    logic got;
    int   snap;
    step();
    snap = v.we ? we_low_total : oe_low_total;
    drive(v.we, v.adr, v.sel, v.wdat);
    e.is_rd = !v.we;
    e.dat   = v.rdat;
    e.due   = cyc_cnt + v.lat;
    sb.push_back(e);
    wait_ack(got);
    if (got) sb_pop();
    idle_bus();
    step();
    check("ack_width", {31'd0, wb_ack_o}, 32'd0);
    check("sram_addr", {12'd0, last_addr}, {12'd0, v.addr});
    check("strobe_cycles", 32'((v.we ? we_low_total : oe_low_total) - snap), 32'(v.low));
    check("be_n", {28'd0, last_be}, {28'd0, v.be});
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] wdat, input logic [31:0] rdat, input logic [19:0] addr);
    vec_t v;
    v.we   = we;
    v.adr  = adr;
    v.sel  = sel;
    v.wdat = wdat;
    v.rdat = rdat;
    v.addr = addr;
    v.lat  = we ? 5 : 3;
    v.low  = 2;
    v.be   = we ? ~sel : 4'h0;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   snap;
    int   seen;
    exp_t e;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 | i;
    mem[4] = 32'h1234_5678;

    vecs[0]  = mk(1'b0, 32'h8000_0010, 4'hf, 32'h0,         32'h1234_5678, 20'h00004);
    vecs[1]  = mk(1'b1, 32'h8000_0020, 4'h4, 32'hAABB_CCDD, 32'h0,         20'h00008);
    vecs[2]  = mk(1'b0, 32'h8000_0020, 4'hf, 32'h0,         32'h00BB_0000, 20'h00008);
    vecs[3]  = mk(1'b1, 32'h0000_0040, 4'hf, 32'h1122_3344, 32'h0,         20'h00010);
    vecs[4]  = mk(1'b0, 32'hFFF0_0042, 4'h1, 32'h0,         32'h1122_3344, 20'hC0010);
    vecs[5]  = mk(1'b1, 32'h0000_0040, 4'h3, 32'h5566_7788, 32'h0,         20'h00010);
    vecs[6]  = mk(1'b0, 32'h0000_0040, 4'hf, 32'h0,         32'h1122_7788, 20'h00010);
    vecs[7]  = mk(1'b1, 32'h0000_0044, 4'h8, 32'hCAFE_BABE, 32'h0,         20'h00011);
    vecs[8]  = mk(1'b0, 32'h0000_0047, 4'hf, 32'h0,         32'hCA00_0000, 20'h00011);
    vecs[9]  = mk(1'b1, 32'h0000_0044, 4'h0, 32'hFFFF_FFFF, 32'h0,         20'h00011);
    vecs[10] = mk(1'b0, 32'h0000_0044, 4'hf, 32'h0,         32'hCA00_0000, 20'h00011);

    // Reset asserted between clock edges must take effect at once.
    #2 rst = 1'b1;
    #1;
    check("rst_ack",     {31'd0, wb_ack_o},     32'd0);
    check("rst_dat_o",   wb_dat_o,              32'd0);
    check("rst_addr",    {12'd0, sram_addr},    32'd0);
    check("rst_data_o",  sram_data_o,           32'd0);
    check("rst_data_oe", {31'd0, sram_data_oe}, 32'd0);
    check("rst_ce_n",    {31'd0, sram_ce_n},    32'd1);
    check("rst_oe_n",    {31'd0, sram_oe_n},    32'd1);
    check("rst_we_n",    {31'd0, sram_we_n},    32'd1);
    check("rst_be_n",    {28'd0, sram_be_n},    32'hf);
    step();
    step();
    rst = 1'b0;
    step();
    safety_en = 1'b1;

    for (int i = 0; i < 11; i++) xfer(vecs[i]);

    // Streaming fetch with stb held high: one ack every four cycles.
    step();
    drive(1'b0, 32'h8000_0000, 4'hf, 32'h0);
    for (int i = 0; i < 4; i++) begin
      e.is_rd = 1'b1;
      e.dat   = 32'hA000_0000 | i;
      e.due   = cyc_cnt + 3 + 4 * i;
      sb.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      wait_ack(got);
      if (!got) break;
      sb_pop();
      if (i == 3) idle_bus();
      else wb_adr_i = wb_adr_i + 32'd4;
    end
    idle_bus();
    step();
    check("stream_ack_low", {31'd0, wb_ack_o}, 32'd0);
    check("stream_leftover", 32'(sb.size()), 32'd0);
    sb.delete();

    // Cycle dropped during READ: controls released next cycle, never an ack.
    step();
    drive(1'b0, 32'h0000_0010, 4'hf, 32'h0);
    step();
    check("abort_rd_oe_low", {31'd0, sram_oe_n}, 32'd0);
    idle_bus();
    step();
    check("abort_rd_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check("abort_rd_oe_n", {31'd0, sram_oe_n}, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_ack_o) seen++;
    end
    check("abort_rd_noack", 32'(seen), 32'd0);
    xfer(vecs[0]);

    // Cycle dropped during W_PULSE: the pulse still completes, ack suppressed.
    step();
    snap = we_low_total;
    drive(1'b1, 32'h0000_0050, 4'hf, 32'h0BAD_F00D);
    step();
    step();
    check("abort_wr_we_low", {31'd0, sram_we_n}, 32'd0);
    idle_bus();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wb_ack_o) seen++;
    end
    check("abort_wr_noack", 32'(seen), 32'd0);
    check("abort_wr_pulse", 32'(we_low_total - snap), 32'd2);
    xfer(mk(1'b0, 32'h0000_0050, 4'hf, 32'h0, 32'h0BAD_F00D, 20'h00014));

    // Reset during the write pulse cuts it immediately.
    step();
    drive(1'b1, 32'h0000_0060, 4'hf, 32'h7777_7777);
    for (int i = 0; i < 5 && sram_we_n; i++) step();
    check("rstw_reached_pulse", {31'd0, sram_we_n}, 32'd0);
    safety_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstw_we_n",    {31'd0, sram_we_n},    32'd1);
    check("rstw_data_oe", {31'd0, sram_data_oe}, 32'd0);
    check("rstw_ce_n",    {31'd0, sram_ce_n},    32'd1);
    check("rstw_ack",     {31'd0, wb_ack_o},     32'd0);
    check("rstw_be_n",    {28'd0, sram_be_n},    32'hf);
    idle_bus();
    step();
    rst = 1'b0;
    step();
    check("rstw_ack_after", {31'd0, wb_ack_o}, 32'd0);
    prev_we_n = sram_we_n;
    prev_oe   = sram_data_oe;
    safety_en = 1'b1;
    xfer(vecs[0]);
    xfer(mk(1'b1, 32'h0000_0060, 4'hf, 32'h0123_4567, 32'h0, 20'h00018));
    xfer(mk(1'b0, 32'h0000_0060, 4'hf, 32'h0, 32'h0123_4567, 20'h00018));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/wb_sram_slave.md
# wb_sram_slave

Wishbone slave that answers instruction-fetch and data-access requests by driving an external asynchronous 32-bit SRAM. It is the responder side of the CPU's Wishbone master ports and sits between the bus (or arbiter) and the board SRAM pins. A state machine times address, output-enable and write-enable phases with registered SRAM controls, and returns a single-cycle `wb_ack_o` per transfer.

## Interface
- `ADDR_WIDTH`, default 20: SRAM word-address width.
- `READ_WAIT`, default 2: cycles `sram_oe_n` is held low before data capture (≥1).
- `WRITE_PULSE`, default 2: cycles `sram_we_n` is held low (≥1).

Ports:
- `clk`  in  1  sole clock; everything is registered on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_we_i`  in  1  1 = write.
- `wb_adr_i`  in  32  byte address.
- `wb_sel_i`  in  4  byte lanes.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, valid while `wb_ack_o` = 1.
- `wb_ack_o`  out  1  transfer complete, one-cycle pulse.
- `sram_addr`  out  ADDR_WIDTH  word address = `wb_adr_i[ADDR_WIDTH+1:2]`.
- `sram_data_i`  in  32  data from the SRAM pads.
- `sram_data_o`  out  32  data to the SRAM pads.
- `sram_data_oe`  out  1  1 = drive pads with `sram_data_o`; 0 = high-Z.
- `sram_ce_n`  out  1  chip enable, active low.
- `sram_oe_n`  out  1  output enable, active low.
- `sram_we_n`  out  1  write enable, active low.
- `sram_be_n`  out  4  byte enables, active low.

## Operation
- All outputs are registered.
- States:
  - `IDLE`: when `wb_cyc_i & wb_stb_i`, latch address, `sel`, `we` and data.
    - Read → `READ`.
    - Write → `W_SETUP`.
  - `READ`: `ce_n`=0, `oe_n`=0, `be_n`=0000. Held for `READ_WAIT` cycles, then capture `sram_data_i` into `wb_dat_o` → `DONE`.
  - `W_SETUP`: `ce_n`=0, `sram_data_oe`=1, `be_n`=~sel, `we_n`=1. One cycle → `W_PULSE`.
  - `W_PULSE`: `we_n`=0 for `WRITE_PULSE` cycles → `W_HOLD`.
  - `W_HOLD`: `we_n`=1; data, address and `be_n` held for one cycle → `DONE`.
  - `DONE`: `ce_n`/`oe_n`/`we_n`=1, `sram_data_oe`=0. `wb_ack_o`=1 only if `wb_cyc_i & wb_stb_i` is still high. Always → `IDLE`.
- Reads always return the full word; the master does lane selection.
- Address bits above `ADDR_WIDTH+1` and bits [1:0] are ignored.
- Wait counter width is `$clog2(max(READ_WAIT, WRITE_PULSE))+1`. It is reloaded on each state entry.
- `wb_dat_o` holds its last captured value outside of `DONE`.

## Timing
- **Reset values:**
  - `wb_ack_o`=0, `wb_dat_o`=0.
  - `sram_addr`=0, `sram_data_o`=0, `sram_data_oe`=0.
  - `sram_ce_n`=1, `sram_oe_n`=1, `sram_we_n`=1, `sram_be_n`=1111.
  - State = `IDLE`, counter = 0.
- **Read:** request sampled in cycle T.
  - `ce_n`/`oe_n` are low in cycles T+1..T+READ_WAIT.
  - `wb_ack_o` is high in cycle T+READ_WAIT+1.
  - Latency is READ_WAIT+1; throughput is one read per READ_WAIT+2 cycles.
- **Write:** request sampled in cycle T.
  - `we_n` is low in cycles T+2..T+1+WRITE_PULSE.
  - `wb_ack_o` is high in cycle T+WRITE_PULSE+3.
- **Back-to-back requests:** a master holding `stb` high continuously (fetch unit) gets its next request sampled in the `IDLE` cycle after `DONE`. The new address must be presented there.
- **Data bus safety:** `we_n` never falls in the same cycle that `sram_data_oe` rises, and `sram_data_oe` never falls in the same cycle that `we_n` rises.
- **`wb_cyc_i` drops during `READ`:** go to `IDLE` next cycle, no ack, SRAM controls deasserted.
- **`wb_cyc_i` drops during a write phase:** the write completes in full (the `we_n` pulse is never truncated), and the ack is suppressed in `DONE`.
- **`rst` during any state:** outputs go to reset values immediately, asynchronously. No ack is issued. A write pulse in progress is cut.
- **Request arriving in a non-`IDLE` state:** ignored until `IDLE`.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs at the reset values listed above, without waiting for a clock edge.
- **Single read:** READ_WAIT=2; read `wb_adr_i`=0x8000_0010 with the SRAM model returning 0x1234_5678.
  - `sram_addr`=0x00004.
  - `oe_n` low for 2 cycles.
  - `wb_ack_o`=1 with `wb_dat_o`=0x1234_5678 exactly 3 cycles after the request, for exactly 1 cycle.
- **Streaming fetch:** `stb` held high, address advances by 4 after each ack starting at 0x8000_0000 → acks every 4 cycles, returning words 0, 1, 2, 3 in order with no duplicates.
- **Byte write:** write 0xAABB_CCDD with `sel`=0100 to 0x8000_0020.
  - `sram_be_n`=1011, `we_n` low for 2 cycles, ack at cycle T+5.
  - A subsequent read returns 0x00BB_0000 when memory was pre-cleared.
- **Abort:** drop `wb_cyc_i` during `READ` → no ack, `IDLE` the next cycle. Drop `wb_cyc_i` during `W_PULSE` → the full `we_n` pulse completes, no ack, and memory is updated.
- **Reset mid-write:** assert `rst` during `W_PULSE` → `we_n`=1 and `sram_data_oe`=0 immediately, and the next request after reset completes normally.
